// File: rtl/ram_arbiter_if.sv
// Bundle of both requester ports and the shared single-port RAM connection.
`default_nettype none

interface ram_arbiter_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
);
  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              gnt0;
  logic              gnt1;
  logic              rvalid0;
  logic              rvalid1;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              busy;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_rdata,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
           ram_we, ram_addr, ram_wdata, busy
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_rdata,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
           ram_we, ram_addr, ram_wdata, busy
  );
endinterface

`default_nettype wire

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin two-requester arbiter for a single-port RAM (rev 1.0).
// Define RAM_ARB_INIT_EN to zero-fill the RAM after reset before accepting requests.
`default_nettype none

module ram_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  wire logic     clock,
  input  wire logic     reset,
  ram_arbiter_if.slave  bus
);

  localparam logic [1:0] c_st_idle   = 2'd0;
  localparam logic [1:0] c_st_access = 2'd1;
`ifdef RAM_ARB_INIT_EN
  localparam logic [1:0] c_st_init   = 2'd2;
  localparam logic [1:0] c_st_reset  = c_st_init;
`else
  localparam logic [1:0] c_st_reset  = c_st_idle;
`endif
  localparam logic [ADDR_W-1:0] c_last_addr = '1;

  logic [1:0]        r_state;
  logic [1:0]        w_next;
  logic              r_last;
  logic              r_owner;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_rd_pend;
  logic              r_rd_owner;
  logic              r_rvalid0;
  logic              r_rvalid1;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;
  logic              w_any;
  logic              w_win;
  logic              w_issue;

  assign w_any   = bus.req0 | bus.req1;
  // On a tie the requester that was not granted last wins.
  assign w_win   = (bus.req0 & bus.req1) ? ~r_last : bus.req1;
  assign w_issue = (r_state == c_st_idle) && w_any;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= c_st_reset;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_st_idle:   if (w_any) w_next = c_st_access;
      c_st_access: w_next = c_st_idle;
`ifdef RAM_ARB_INIT_EN
      c_st_init:   if (r_addr == c_last_addr) w_next = c_st_idle;
`endif
      default:     w_next = c_st_idle;
    endcase
  end

  // Gated by reset so a grant or write in flight never shows while reset is high.
  always_comb begin
    bus.gnt0   = 1'b0;
    bus.gnt1   = 1'b0;
    bus.ram_we = 1'b0;
    bus.busy   = 1'b0;
    case (r_state)
      c_st_access: begin
        bus.gnt0   = ~reset & ~r_owner;
        bus.gnt1   = ~reset & r_owner;
        bus.ram_we = ~reset & r_we;
      end
`ifdef RAM_ARB_INIT_EN
      c_st_init: begin
        bus.ram_we = ~reset;
        bus.busy   = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // The command address register doubles as the zero-fill sweep counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_last  <= 1'b1;
      r_owner <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      if (w_issue) begin
        r_last  <= w_win;
        r_owner <= w_win;
        r_we    <= w_win ? bus.we1    : bus.we0;
        r_addr  <= w_win ? bus.addr1  : bus.addr0;
        r_wdata <= w_win ? bus.wdata1 : bus.wdata0;
      end
`ifdef RAM_ARB_INIT_EN
      if ((r_state == c_st_init) && (r_addr != c_last_addr)) begin
        r_addr <= r_addr + 1'b1;
      end
`endif
    end
  end

  // Read return: tag at issue, capture RAM output one cycle later.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rd_pend  <= 1'b0;
      r_rd_owner <= 1'b0;
      r_rvalid0  <= 1'b0;
      r_rvalid1  <= 1'b0;
      r_rdata0   <= '0;
      r_rdata1   <= '0;
    end else begin
      r_rd_pend  <= (r_state == c_st_access) && !r_we;
      r_rd_owner <= r_owner;
      r_rvalid0  <= r_rd_pend && !r_rd_owner;
      r_rvalid1  <= r_rd_pend && r_rd_owner;
      if (r_rd_pend && !r_rd_owner) r_rdata0 <= bus.ram_rdata;
      if (r_rd_pend && r_rd_owner)  r_rdata1 <= bus.ram_rdata;
    end
  end

  assign bus.ram_addr  = r_addr;
  assign bus.ram_wdata = r_wdata;
  assign bus.rvalid0   = r_rvalid0;
  assign bus.rvalid1   = r_rvalid1;
  assign bus.rdata0    = r_rdata0;
  assign bus.rdata1    = r_rdata1;

endmodule

`default_nettype wire

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: vector table plus corner-case sequences.
`default_nettype none

module tb_ram_arbiter;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   rv0_seen = 0;
  logic mon_en = 1'b0;
  logic ram_clr = 1'b1;
  logic [7:0] mem [32];

`ifdef RAM_ARB_INIT_EN
  localparam logic c_busy_rst = 1'b1;
`else
  localparam logic c_busy_rst = 1'b0;
`endif

  ram_arbiter_if #(.DATA_W(8), .ADDR_W(5)) bus ();

  ram_arbiter #(.DATA_W(8), .ADDR_W(5)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Synchronous RAM model with registered output.
  always @(posedge clock) begin
    if (ram_clr) begin
      for (int i = 0; i < 32; i++) mem[i] <= 8'h00;
    end else if (bus.ram_we) begin
      mem[bus.ram_addr] <= bus.ram_wdata;
    end
    bus.ram_rdata <= mem[bus.ram_addr];
  end

  always @(negedge clock) if (mon_en && bus.rvalid0) rv0_seen++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       req0, we0; logic [4:0] addr0; logic [7:0] wdata0;
    logic       req1, we1; logic [4:0] addr1; logic [7:0] wdata1;
    logic       gnt0, gnt1, ram_we; logic [4:0] ram_addr; logic [7:0] ram_wdata;
    logic       rvalid0, rvalid1; logic [7:0] rdata0, rdata1;
  } vec_t;

  vec_t vec [16];

  function automatic vec_t v(logic r0, logic w0, logic [4:0] a0, logic [7:0] d0,
                             logic r1, logic w1, logic [4:0] a1, logic [7:0] d1,
                             logic g0, logic g1, logic rw, logic [4:0] ra, logic [7:0] rd,
                             logic v0, logic v1, logic [7:0] q0, logic [7:0] q1);
    vec_t t;
    t.req0 = r0; t.we0 = w0; t.addr0 = a0; t.wdata0 = d0;
    t.req1 = r1; t.we1 = w1; t.addr1 = a1; t.wdata1 = d1;
    t.gnt0 = g0; t.gnt1 = g1; t.ram_we = rw; t.ram_addr = ra; t.ram_wdata = rd;
    t.rvalid0 = v0; t.rvalid1 = v1; t.rdata0 = q0; t.rdata1 = q1;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
  endtask

  task automatic do_reset();
    int n;
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    chk("reset_outputs", {bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.rdata0,
        bus.rdata1, bus.ram_we, bus.ram_addr, bus.ram_wdata}, 64'd0);
    chk("reset_busy", bus.busy, c_busy_rst);
    reset = 1'b0;
`ifdef RAM_ARB_INIT_EN
    n = 0;
    while (bus.busy && n < 40) begin
      tick();
      n++;
    end
    chk("init_wait", bus.busy, 1'b0);
`else
    n = 0;
`endif
  endtask

  // Issue one access on port k and return in G+1 (write) or G+2 (read).
  task automatic access(input int k, input logic we, input logic [4:0] a, input logic [7:0] d);
    int n;
    logic g;
    if (k == 0) begin
      bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d;
    end else begin
      bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d;
    end
    n = 0;
    g = 1'b0;
    while (!g && n < 8) begin
      tick();
      n++;
      g = (k == 0) ? bus.gnt0 : bus.gnt1;
    end
    chk($sformatf("access%0d_gnt", k), g, 1'b1);
    tick();
    if (k == 0) bus.req0 = 1'b0; else bus.req1 = 1'b0;
    if (!we) tick();
  endtask

  initial begin
    logic pg0, pg1;
    logic [1:0] exp2;
    int n;

    vec[0]  = v(1,1,5,8'h2A, 0,0,0,8'h00,  1,0,1,5,8'h2A, 0,0,8'h00,8'h00);
    vec[1]  = v(0,0,5,8'h2A, 0,0,0,8'h00,  0,0,0,5,8'h2A, 0,0,8'h00,8'h00);
    vec[2]  = v(1,0,5,8'h2A, 0,0,0,8'h00,  1,0,0,5,8'h2A, 0,0,8'h00,8'h00);
    vec[3]  = v(0,0,5,8'h2A, 0,0,0,8'h00,  0,0,0,5,8'h2A, 0,0,8'h00,8'h00);
    vec[4]  = v(0,0,5,8'h2A, 0,0,0,8'h00,  0,0,0,5,8'h2A, 1,0,8'h2A,8'h00);
    vec[5]  = v(0,0,5,8'h2A, 0,0,0,8'h00,  0,0,0,5,8'h2A, 0,0,8'h2A,8'h00);
    vec[6]  = v(1,1,1,8'h11, 1,1,2,8'h22,  0,1,1,2,8'h22, 0,0,8'h2A,8'h00);
    vec[7]  = v(1,1,1,8'h11, 0,0,2,8'h22,  0,0,0,2,8'h22, 0,0,8'h2A,8'h00);
    vec[8]  = v(1,1,1,8'h11, 0,0,2,8'h22,  1,0,1,1,8'h11, 0,0,8'h2A,8'h00);
    vec[9]  = v(0,0,1,8'h11, 1,0,2,8'h22,  0,0,0,1,8'h11, 0,0,8'h2A,8'h00);
    vec[10] = v(0,0,1,8'h11, 1,0,2,8'h22,  0,1,0,2,8'h22, 0,0,8'h2A,8'h00);
    vec[11] = v(0,0,1,8'h11, 0,0,2,8'h22,  0,0,0,2,8'h22, 0,0,8'h2A,8'h00);
    vec[12] = v(1,0,1,8'h11, 0,0,2,8'h22,  1,0,0,1,8'h11, 0,1,8'h2A,8'h22);
    vec[13] = v(0,0,1,8'h11, 0,0,2,8'h22,  0,0,0,1,8'h11, 0,0,8'h2A,8'h22);
    vec[14] = v(0,0,1,8'h11, 0,0,2,8'h22,  0,0,0,1,8'h11, 1,0,8'h11,8'h22);
    vec[15] = v(0,0,1,8'h11, 0,0,2,8'h22,  0,0,0,1,8'h11, 0,0,8'h11,8'h22);

    do_reset();
    ram_clr = 1'b0;

    // Contention from reset: grants alternate 0,1,0,1 two cycles apart.
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 5'd0;
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 5'd1;
    pg0 = 1'b0; pg1 = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      exp2 = (c % 4 == 1) ? 2'b10 : ((c % 4 == 3) ? 2'b01 : 2'b00);
      chk($sformatf("rr_cycle%0d", c), {bus.gnt0, bus.gnt1}, exp2);
      bus.req0 = !pg0;
      bus.req1 = !pg1;
      pg0 = bus.gnt0;
      pg1 = bus.gnt1;
    end
    idle_inputs();
    repeat (4) tick();

    for (int i = 0; i < 16; i++) begin
      bus.req0 = vec[i].req0; bus.we0 = vec[i].we0; bus.addr0 = vec[i].addr0; bus.wdata0 = vec[i].wdata0;
      bus.req1 = vec[i].req1; bus.we1 = vec[i].we1; bus.addr1 = vec[i].addr1; bus.wdata1 = vec[i].wdata1;
      tick();
      chk($sformatf("vec%0d", i),
          {bus.gnt0, bus.gnt1, bus.ram_we, bus.ram_addr, bus.ram_wdata,
           bus.rvalid0, bus.rvalid1, bus.rdata0, bus.rdata1},
          {vec[i].gnt0, vec[i].gnt1, vec[i].ram_we, vec[i].ram_addr, vec[i].ram_wdata,
           vec[i].rvalid0, vec[i].rvalid1, vec[i].rdata0, vec[i].rdata1});
    end
    idle_inputs();
    tick();

    // Requester 1 fills the RAM then reads it back; requester 0 must see nothing.
    rv0_seen = 0;
    mon_en = 1'b1;
    for (int j = 0; j < 32; j++) access(1, 1'b1, 5'(j), 8'(j + 1));
    for (int j = 0; j < 32; j++) begin
      access(1, 1'b0, 5'(j), 8'h00);
      chk($sformatf("sweep_read%0d", j), {bus.rvalid1, bus.rdata1}, {1'b1, 8'(j + 1)});
    end
    tick();
    mon_en = 1'b0;
    chk("sweep_no_rvalid0", rv0_seen, 0);

`ifdef RAM_ARB_INIT_EN
    // Zero-fill sweep with a request pending the whole time.
    idle_inputs();
    bus.req0 = 1'b1;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    for (int j = 0; j < 32; j++) begin
      if (j > 0) tick();
      chk($sformatf("init_cycle%0d", j),
          {bus.ram_we, bus.ram_addr, bus.ram_wdata, bus.busy, bus.gnt0},
          {1'b1, 5'(j), 8'h00, 1'b1, 1'b0});
    end
    tick();
    chk("init_done", {bus.busy, bus.ram_we, bus.gnt0}, 3'b000);
    tick();
    chk("init_first_gnt", {bus.gnt0, bus.gnt1}, 2'b10);
    bus.req0 = 1'b0;
    repeat (4) tick();
`endif

    // Reset in the cycle after a read grant discards the pending return.
    idle_inputs();
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 5'd3;
    n = 0;
    pg0 = 1'b0;
    while (!pg0 && n < 8) begin
      tick();
      n++;
      pg0 = bus.gnt0;
    end
    chk("midread_gnt", pg0, 1'b1);
    tick();
    bus.req0 = 1'b0;
    reset = 1'b1;
    tick();
    chk("midread_reset_outputs", {bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.rdata0,
        bus.rdata1, bus.ram_we, bus.ram_addr, bus.ram_wdata}, 64'd0);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("midread_no_rvalid%0d", c), {bus.rvalid0, bus.rvalid1, bus.gnt0}, 3'b000);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
